// File: rtl/menu_select_if.sv
// Menu controller bus: keyboard decoder inputs and renderer-facing outputs.
// The FSM uses the slave view; the keyboard/renderer side uses master.
interface menu_select_if #(
  parameter int XW = 11,
  parameter int YW = 10
);
  logic [7:0]    keycode;
  logic [5:0]    key;
  logic          title_visible;
  logic          car_select_visible;
  logic          control_select_visible;
  logic          track_visible;
  logic          arrow_visible;
  logic [XW-1:0] arrow_xpos;
  logic [YW-1:0] arrow_ypos;
  logic [3:0]    car;
  logic [3:0]    control;
  logic          lap_timer_start;
  logic          game_active;

  modport master (
    output keycode, key,
    input  title_visible, car_select_visible, control_select_visible,
           track_visible, arrow_visible, arrow_xpos, arrow_ypos,
           car, control, lap_timer_start, game_active
  );

  modport slave (
    input  keycode, key,
    output title_visible, car_select_visible, control_select_visible,
           track_visible, arrow_visible, arrow_xpos, arrow_ypos,
           car, control, lap_timer_start, game_active
  );
endinterface

// File: rtl/menu_select_fsm.sv
// Racer front-end menu: TITLE -> CAR_SEL -> CTRL_SEL -> GAME with wrap-around
// cursor navigation, ESC back-navigation and key edge detection.
// Optional: define MENU_AUTO_REPEAT_EN for auto-repeat of held LEFT/RIGHT
// in the select screens.
module menu_select_fsm #(
  parameter int          N_CARS       = 4,
  parameter int          N_CTRLS      = 2,
  parameter int          XW           = 11,
  parameter int          YW           = 10,
  parameter int          ARROW_X0     = 208,
  parameter int          ARROW_STEP   = 192,
  parameter int          CAR_ARROW_Y  = 480,
  parameter int          CTRL_ARROW_Y = 576,
  parameter logic [23:0] REPEAT_DLY   = 24'd6500000
) (
  input logic          pclk,
  input logic          rst_n,
  menu_select_if.slave bus
);

  typedef enum logic [1:0] {TITLE, CAR_SEL, CTRL_SEL, GAME} state_t;

  localparam logic [3:0] CAR_LAST  = 4'(N_CARS - 1);
  localparam logic [3:0] CTRL_LAST = 4'(N_CTRLS - 1);

  state_t     state;
  logic [3:0] car_cur, ctrl_cur;
  logic [5:0] key_prev;
  logic [7:0] keycode_prev;

  logic ev, ev_l, ev_r, ev_e, ev_x, any_ev;

  // Unsigned arrow position, truncated to XW bits.
  function automatic logic [XW-1:0] arrow_x(input logic [3:0] c);
    logic [31:0] t;
    t = 32'(ARROW_X0) + 32'(c) * 32'(ARROW_STEP);
    return t[XW-1:0];
  endfunction

`ifdef MENU_AUTO_REPEAT_EN
  state_t      state_q;
  logic [23:0] rpt_cnt;
  logic        rpt_hold, rpt_fire;

  // A held LEFT/RIGHT in a select screen counts toward a repeat event;
  // any key change or state change breaks the hold.
  always_comb begin
    rpt_hold = (state == CAR_SEL || state == CTRL_SEL) && (state == state_q) &&
               (key_prev == bus.key) &&
               (bus.key == 6'b000100 || bus.key == 6'b001000);
    rpt_fire = rpt_hold && (rpt_cnt == REPEAT_DLY - 24'd1);
  end

  // Repeat counter restarts after every fire and whenever the hold breaks.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      rpt_cnt <= '0;
      state_q <= TITLE;
    end else begin
      state_q <= state;
      rpt_cnt <= (rpt_hold && !rpt_fire) ? rpt_cnt + 24'd1 : '0;
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt = ^REPEAT_DLY;
`endif

  // Key event decode: rising edge of a single bit of a one-hot key value.
  always_comb begin
    ev     = $onehot(bus.key) && |(bus.key & ~key_prev);
    ev_l   = ev && bus.key[2];
    ev_r   = ev && bus.key[3];
    ev_e   = ev && bus.key[4];
    ev_x   = ev && bus.key[5];
    any_ev = (bus.keycode != 8'h00) && (keycode_prev == 8'h00);
`ifdef MENU_AUTO_REPEAT_EN
    ev_l   = ev_l || (rpt_fire && bus.key[2]);
    ev_r   = ev_r || (rpt_fire && bus.key[3]);
`endif
  end

  // Menu FSM; outputs are registered from the current (pre-edge) state.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state                      <= TITLE;
      car_cur                    <= '0;
      ctrl_cur                   <= '0;
      key_prev                   <= '0;
      keycode_prev               <= '0;
      bus.car                    <= '0;
      bus.control                <= '0;
      bus.title_visible          <= 1'b1;
      bus.car_select_visible     <= 1'b0;
      bus.control_select_visible <= 1'b0;
      bus.track_visible          <= 1'b0;
      bus.arrow_visible          <= 1'b0;
      bus.arrow_xpos             <= '0;
      bus.arrow_ypos             <= '0;
      bus.lap_timer_start        <= 1'b0;
      bus.game_active            <= 1'b0;
    end else begin
      key_prev     <= bus.key;
      keycode_prev <= bus.keycode;

      case (state)
        TITLE: if (any_ev) begin
          state   <= CAR_SEL;
          car_cur <= bus.car;
        end
        CAR_SEL: begin
          if (ev_e) begin
            bus.car  <= car_cur;
            ctrl_cur <= bus.control;
            state    <= CTRL_SEL;
          end else if (ev_x) state <= TITLE;
          else if (ev_r) car_cur <= (car_cur == CAR_LAST) ? 4'd0 : car_cur + 4'd1;
          else if (ev_l) car_cur <= (car_cur == 4'd0) ? CAR_LAST : car_cur - 4'd1;
        end
        CTRL_SEL: begin
          if (ev_e) begin
            bus.control <= ctrl_cur;
            state       <= GAME;
          end else if (ev_x) state <= CAR_SEL;
          else if (ev_r) ctrl_cur <= (ctrl_cur == CTRL_LAST) ? 4'd0 : ctrl_cur + 4'd1;
          else if (ev_l) ctrl_cur <= (ctrl_cur == 4'd0) ? CTRL_LAST : ctrl_cur - 4'd1;
        end
        default: if (ev_x) state <= TITLE;
      endcase

      bus.title_visible          <= (state == TITLE);
      bus.car_select_visible     <= (state == CAR_SEL);
      bus.control_select_visible <= (state == CTRL_SEL);
      bus.track_visible          <= (state == GAME);
      bus.arrow_visible          <= (state == CAR_SEL) || (state == CTRL_SEL);
      bus.game_active            <= (state == GAME);
      // Fires on the first cycle game_active rises.
      bus.lap_timer_start        <= (state == GAME) && !bus.game_active;
      case (state)
        CAR_SEL: begin
          bus.arrow_xpos <= arrow_x(car_cur);
          bus.arrow_ypos <= YW'(CAR_ARROW_Y);
        end
        CTRL_SEL: begin
          bus.arrow_xpos <= arrow_x(ctrl_cur);
          bus.arrow_ypos <= YW'(CTRL_ARROW_Y);
        end
        default: begin
          bus.arrow_xpos <= '0;
          bus.arrow_ypos <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/menu_select_fsm.md
Name: menu_select_fsm

Overview:
- Parametrised menu controller for the racer front end: title → car select → control select → game.
- Supports N selectable cars and M control schemes, with left/right wrap-around navigation, ESC back-navigation and key edge detection.
- Sits between the keyboard decoder (keycode, one-hot key) and the sprite/screen renderers. Drives visibility flags, arrow sprite position, the chosen car/control, and the lap timer start pulse.

Parameters:
- N_CARS, 4, number of car options (2..15).
- N_CTRLS, 2, number of control options (2..15).
- XW, 11, width of arrow x coordinate.
- YW, 10, width of arrow y coordinate.
- ARROW_X0, 208, arrow x for option index 0.
- ARROW_STEP, 192, x increment per option index.
- CAR_ARROW_Y, 480, arrow y on car screen.
- CTRL_ARROW_Y, 576, arrow y on control screen.
- REPEAT_DLY, 24'd6500000, auto-repeat interval in pclk cycles (used only with the optional feature).

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active low.
- keycode  in  8  raw scan code; nonzero = some key down.
- key  in  6  one-hot decoded key: [0]UP [1]DOWN [2]LEFT [3]RIGHT [4]ENTER [5]ESC.
- title_visible  out  1  title screen enable.
- car_select_visible  out  1  car screen enable; car sprites also shown.
- control_select_visible  out  1  control screen enable.
- track_visible  out  1  track and player enable.
- arrow_visible  out  1  selection arrow enable.
- arrow_xpos  out  XW  arrow x.
- arrow_ypos  out  YW  arrow y.
- car  out  4  committed car index, 0..N_CARS-1.
- control  out  4  committed control index, 0..N_CTRLS-1.
- lap_timer_start  out  1  one-cycle pulse on entering GAME.
- game_active  out  1  level, high while in GAME.

Behaviour:
- Reset (rst_n=0 at posedge): state=TITLE, cursor indices=0, car=0, control=0.
  - title_visible=1; all other visibility flags 0.
  - arrow_xpos=0, arrow_ypos=0, lap_timer_start=0, game_active=0.
  - Edge-detect registers cleared.
  - Reset asserted mid-operation aborts any state and returns to these values on the next edge.
- Edge detection: key and keycode are registered each cycle.
  - A key event = rising edge of exactly one key bit (key_prev bit 0 → 1).
  - key values that are not one-hot (more than one bit set) are ignored: no event, and the previous value is still updated.
  - any_event = keycode != 0 while the previous keycode == 0.
  - Holding a key produces exactly one event.
- States and transitions (one event per cycle; ENTER/ESC take priority over LEFT/RIGHT; UP/DOWN are ignored):
  - TITLE: any_event → CAR_SEL; car cursor is loaded with committed car.
  - CAR_SEL:
    - RIGHT: cursor+1, wraps N_CARS-1 → 0.
    - LEFT: cursor-1, wraps 0 → N_CARS-1.
    - ENTER: car ← cursor; → CTRL_SEL; control cursor is loaded with committed control.
    - ESC: → TITLE; car unchanged.
  - CTRL_SEL:
    - RIGHT/LEFT: same wrap rules with N_CTRLS.
    - ENTER: control ← cursor; → GAME.
    - ESC: → CAR_SEL; control unchanged.
  - GAME:
    - ESC → TITLE.
    - All other keys ignored.
    - car and control are held.
- Outputs are registered and reflect the current state, i.e. they update one cycle after the transition edge:
  - TITLE: title_visible=1, arrow_visible=0.
  - CAR_SEL: car_select_visible=1, arrow_visible=1, arrow_xpos = ARROW_X0 + cursor*ARROW_STEP, arrow_ypos = CAR_ARROW_Y.
  - CTRL_SEL: control_select_visible=1, arrow_visible=1, arrow_xpos = ARROW_X0 + cursor*ARROW_STEP, arrow_ypos = CTRL_ARROW_Y.
  - GAME: track_visible=1, game_active=1, arrow_visible=0.
  - arrow_xpos when not in a select state: 0.
  - Arrow arithmetic is unsigned, truncated to XW bits.
- lap_timer_start: high for exactly one cycle, the first cycle game_active=1. It re-fires on every GAME entry.
- Exactly one of title/car_select/control_select/track visible is high at any time after reset.

Optional Feature:
- Macro: MENU_AUTO_REPEAT_EN.
- Defined:
  - A held LEFT or RIGHT in CAR_SEL/CTRL_SEL generates an additional event every REPEAT_DLY cycles after the initial edge event.
  - 24-bit repeat counter; it clears on key release, on a key change, or on a state change.
  - ENTER and ESC never repeat.
- Undefined: no counter logic; strictly one event per press.

Test Plan:
- Release reset, then keycode 0x00→0x1C → state CAR_SEL; next cycle car_select_visible=1, arrow_xpos=208, arrow_ypos=480.
- In CAR_SEL, press LEFT once from cursor 0 → cursor 3, arrow_xpos=208+3*192=784. Press RIGHT → arrow_xpos=208.
- In CAR_SEL, hold RIGHT 100 cycles (no MENU_AUTO_REPEAT_EN) → cursor advances exactly 1 (arrow_xpos=400). key=6'b001100 → no movement.
- Press RIGHT×2, ENTER, RIGHT, ENTER → car=2, control=1, track_visible=1, lap_timer_start high exactly 1 cycle.
- In GAME press ESC → title_visible=1, car=2 retained. Re-enter GAME → lap_timer_start pulses again.
- Drive rst_n=0 for 1 cycle while in CTRL_SEL → next cycle title_visible=1, car=0, control=0, arrow_visible=0.
